uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one UART transmitter between NREQ byte requesters. It sits between the requesters and the transmitter inside uart_top. It accepts one byte per grant, latches it, and issues a one-cycle tx_start with the byte on tx_din. It then waits for the transmitter's tx_done tick and enforces a programmable inter-frame gap before the next arbitration.

Parameters:
NREQ, 4, number of requesters (2..8)
DBIT, 8, data bits per frame (matches transmitter DBIT)
GAP_CYCLES, 16, idle clk cycles after tx_done before next grant (0 = no gap)
TIMEOUT, 65535, max clk cycles in WAIT_DONE before abort (0 = disabled)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  requester i has a byte pending
req_data  in  NREQ*DBIT  byte of requester i at [i*DBIT +: DBIT]
req_ready  out  NREQ  one-hot, 1-cycle accept pulse to the winner
tx_start  out  1  1-cycle start pulse to transmitter
tx_din  out  DBIT  registered byte to transmitter, stable from START until next grant
tx_done  in  1  1-cycle completion tick from transmitter
grant_id  out  clog2(NREQ)  index of the last granted requester
busy  out  1  high in every state except IDLE
timeout_err  out  1  1-cycle pulse when a TIMEOUT abort occurs

Behaviour:
- Reset (async, any state): state=IDLE; req_ready=0; tx_start=0; tx_din=0; grant_id=0; busy=0; timeout_err=0; gap/timeout counters=0; rr pointer=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, START, WAIT_DONE, GAP.
- IDLE: if any req_valid, pick the first set bit searching ptr+1, ptr+2, … with wrap modulo NREQ.
  - Same cycle: req_ready[w]=1; tx_din<=req_data[w]; grant_id<=w; ptr<=w; next state START.
  - Handshake completes on req_ready & req_valid. Requesters must hold valid/data until ready.
  - A valid deasserted before the grant is simply not considered.
- START: tx_start=1 for exactly one cycle; next state WAIT_DONE. Latency from accepted request to tx_start is 1 cycle.
- WAIT_DONE: tx_start=0; the timeout counter increments each cycle.
  - On tx_done: go to GAP, or to IDLE if GAP_CYCLES=0.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without tx_done: pulse timeout_err, go to IDLE. The byte is dropped, not retried.
- GAP: the counter counts GAP_CYCLES cycles, then the FSM returns to IDLE. The earliest next req_ready is GAP_CYCLES+1 cycles after the tx_done cycle.
- tx_done outside WAIT_DONE is ignored.
- Simultaneous requests: exactly one winner per arbitration. The winner becomes lowest priority next round.
- A single continuous requester is granted back-to-back, separated only by frame time plus gap.
- Counters are wide enough for their parameter and must not wrap before their terminal count.

Optional Feature:
UART_SCHED_HDR_EN
- Defined: each grant sends two frames. The first is a header byte {2'b11, {(DBIT-2-clog2(NREQ)){1'b0}}, grant_id}, the second is the data byte.
  - FSM adds HDR_START and HDR_WAIT before START.
  - The data byte is held in an internal register until the header's tx_done.
  - The GAP applies only after the data frame. TIMEOUT applies to each frame independently; a header timeout drops both frames.
- Undefined: single data frame per grant, exactly as described above.

Test Plan:
- Reset, then req_valid=4'b0001 with data 0xA5 → req_ready[0] pulse; tx_start 1 cycle later with tx_din=0xA5; grant_id=0; busy high until GAP ends.
- req_valid=4'b1111 held with data 0x10,0x11,0x12,0x13 → transmitted order 0x10,0x11,0x12,0x13, then 0x10 again.
- req_valid=4'b0101 after last grant was 0 → grant 2, then 0. Requester 2 asserting at the same time as 0 is granted first.
- GAP_CYCLES=16: tx_done pulsed 50 cycles after tx_start, request pending → next req_ready exactly 17 cycles after tx_done.
- TIMEOUT=100, tx_done never pulsed → timeout_err pulses 100 cycles after WAIT_DONE entry; FSM in IDLE; next request granted normally.
- reset_n dropped during WAIT_DONE → all outputs 0 immediately; a later tx_done is ignored; after release, requester 0 has priority. With UART_SCHED_HDR_EN, grant of requester 3 (data 0x3C) → tx_din sequence 0xC3 then 0x3C.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
//------------------------------------------------------------------------------
// uart_tx_scheduler
//
// Round-robin scheduler that shares one UART transmitter between NREQ byte
// requesters. One byte is accepted per grant and latched. The transmitter gets
// a one-cycle tx_start with the byte on tx_din. The scheduler then waits for
// tx_done and holds off for GAP_CYCLES idle cycles before it arbitrates again.
// A frame that never completes is abandoned after TIMEOUT cycles.
//
// Optional build macro:
//   UART_SCHED_HDR_EN  - each grant sends a header byte
//                        {2'b11, zeros, grant_id} followed by the data byte.
//                        Without the macro, one data frame is sent per grant.
//
// Parameters:
//   NREQ        number of requesters (2..8)
//   DBIT        data bits per frame
//   GAP_CYCLES  idle cycles after the final tx_done before the next grant
//   TIMEOUT     cycles allowed per frame in a wait state, 0 disables the limit
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   req_valid    [NREQ]       requester i has a byte pending
//   req_data     [NREQ*DBIT]  byte of requester i at [i*DBIT +: DBIT]
//   req_ready    [NREQ]       one-hot accept pulse to the winner
//   tx_start     start pulse to the transmitter
//   tx_din       [DBIT]       byte to the transmitter, held until the next grant
//   tx_done      completion tick from the transmitter
//   grant_id     [clog2 NREQ] index of the last granted requester
//   busy         high in every state except IDLE
//   timeout_err  one-cycle pulse when a frame is abandoned
//------------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int NREQ       = 4,
    parameter int DBIT       = 8,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DBIT-1:0]      req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      tx_start,
    output logic [DBIT-1:0]           tx_din,
    input  logic                      tx_done,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int ID_W    = $clog2(NREQ);
    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
    // The counter only ever has to reach CNT_MAX-1.
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NREQ - 1);
    localparam logic [ID_W:0]    NREQ_X   = (ID_W+1)'(NREQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_START,
        S_HDR_WAIT,
        S_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [DBIT-1:0]    tx_din_q, tx_din_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic [NREQ-1:0]    req_ready_c;

`ifdef UART_SCHED_HDR_EN
    logic [DBIT-1:0]    data_hold_q, data_hold_d;

    // Header byte: two marker bits on top, requester index at the bottom.
    function automatic logic [DBIT-1:0] hdr_byte(input logic [ID_W-1:0] id);
        logic [DBIT-1:0] b;
        b              = '0;
        b[DBIT-1 -: 2] = 2'b11;
        b[ID_W-1:0]    = id;
        return b;
    endfunction
`endif

    // Round-robin winner search, starting one past the last winner.
    logic               win_found;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W:0]      cand;
    logic [DBIT-1:0]    win_data;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= NREQ_X) begin
                cand = cand - NREQ_X;
            end
            if (!win_found && req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
        end
        win_data = req_data[int'(win_idx)*DBIT +: DBIT];
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        tx_din_d      = tx_din_q;
        grant_id_d    = grant_id_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        req_ready_c   = '0;
`ifdef UART_SCHED_HDR_EN
        data_hold_d   = data_hold_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (win_found) begin
                    req_ready_c[win_idx] = 1'b1;
                    ptr_d                = win_idx;
                    grant_id_d           = win_idx;
`ifdef UART_SCHED_HDR_EN
                    tx_din_d             = hdr_byte(win_idx);
                    data_hold_d          = win_data;
                    state_d              = S_HDR_START;
`else
                    tx_din_d             = win_data;
                    state_d              = S_START;
`endif
                end
            end

`ifdef UART_SCHED_HDR_EN
            S_HDR_START: begin
                cnt_d   = '0;
                state_d = S_HDR_WAIT;
            end

            S_HDR_WAIT: begin
                if (tx_done) begin
                    tx_din_d = data_hold_q;
                    cnt_d    = '0;
                    state_d  = S_START;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    // Header lost: the data byte is dropped with it.
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_DONE;
            end

            S_WAIT_DONE: begin
                if (tx_done) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= PTR_RST;
            tx_din_q      <= '0;
            grant_id_q    <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`ifdef UART_SCHED_HDR_EN
            data_hold_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            tx_din_q      <= tx_din_d;
            grant_id_q    <= grant_id_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`ifdef UART_SCHED_HDR_EN
            data_hold_q   <= data_hold_d;
`endif
        end
    end

    // req_ready is a same-cycle grant, so it is combinational from IDLE.
    // Gating with reset_n keeps it low while reset is asserted even though
    // IDLE would otherwise answer a pending request.
    assign req_ready   = reset_n ? req_ready_c : '0;
    assign tx_start    = (state_q == S_START) || (state_q == S_HDR_START);
    assign tx_din      = tx_din_q;
    assign grant_id    = grant_id_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_err_q;

endmodule
